// File: rtl/npx_pkg.sv
// Shared types and constants for the WS2812B frame scheduler.
package npx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      LATCH
   } npx_state_t;

   localparam int         NPX_WORD_W    = 24;
   localparam logic [2:0] NPX_MAX_SHIFT = 3'd4;

   // Byte lanes of the serializer word: {B, R, G}
   localparam int NPX_B_LSB = 16;
   localparam int NPX_R_LSB = 8;
   localparam int NPX_G_LSB = 0;

endpackage

// File: rtl/npx_scale.sv
// Brightness scaling: clamps the shift to NPX_MAX_SHIFT and right-shifts each colour
// component into its byte lane of the pixel word. Purely combinational.
module npx_scale
   import npx_pkg::*;
(
   input  logic [7:0]            r_i,
   input  logic [7:0]            g_i,
   input  logic [7:0]            b_i,
   input  logic [2:0]            shift_i,
   output logic [NPX_WORD_W-1:0] word_o
);

   logic [2:0] shift_clamped;

   always_comb begin
      shift_clamped = (shift_i > NPX_MAX_SHIFT) ? NPX_MAX_SHIFT : shift_i;
      word_o                  = '0;
      word_o[NPX_B_LSB +: 8]  = b_i >> shift_clamped;
      word_o[NPX_R_LSB +: 8]  = r_i >> shift_clamped;
      word_o[NPX_G_LSB +: 8]  = g_i >> shift_clamped;
   end

endmodule

// File: rtl/npx_frame_scheduler.sv
// Frame-level controller for the WS2812B serializer: triggers, snapshot, per-LED handshake
// and latch gap. Blink gating is compiled in only when NPX_BLINK_EN is defined.
module npx_frame_scheduler
   import npx_pkg::*;
#(
   parameter int NUM_LEDS     = 60,
   parameter int LATCH_CYCLES = 960,
   parameter int FRAME_DIV    = 200000,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            base_r,
   input  logic [7:0]            base_g,
   input  logic [7:0]            base_b,
   input  logic [2:0]            shift,
   input  logic                  blink_en,
   input  logic                  frame_req,
   output logic                  px_valid,
   output logic [NPX_WORD_W-1:0] px_data,
   output logic                  px_last,
   input  logic                  px_ready,
   output logic                  busy,
   output logic                  frame_done,
   output logic [7:0]            frame_cnt
);

   localparam int TICK_W = $clog2(FRAME_DIV + 1);
   localparam int LAT_W  = $clog2(LATCH_CYCLES + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_DIV - 1);
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATCH_CYCLES - 1);
   localparam logic [7:0]        LED_LAST  = 8'(NUM_LEDS - 1);

   npx_state_t            state_q, state_d;
   logic                  pending_q, pending_d;
   logic [TICK_W-1:0]     tick_q, tick_d;
   logic [LAT_W-1:0]      lat_q, lat_d;
   logic [7:0]            led_idx_q, led_idx_d;
   logic [7:0]            frame_cnt_q, frame_cnt_d;
   logic [NPX_WORD_W-1:0] word_q, word_d;
   logic [NPX_WORD_W-1:0] scaled_word;
   logic                  tick_wrap;
   logic                  trigger;
   logic                  blank;

   npx_scale u_scale (
      .r_i     (base_r),
      .g_i     (base_g),
      .b_i     (base_b),
      .shift_i (shift),
      .word_o  (scaled_word)
   );

   assign tick_wrap = (tick_q == TICK_LAST);
   assign trigger   = frame_req | tick_wrap;
   assign tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
   assign busy      = (state_q != IDLE);
   assign frame_cnt = frame_cnt_q;

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      lat_d       = lat_q;
      led_idx_d   = led_idx_q;
      frame_cnt_d = frame_cnt_q;
      word_d      = word_q;
      px_valid    = 1'b0;
      px_data     = '0;
      px_last     = 1'b0;
      frame_done  = 1'b0;

      // Triggers arriving mid-frame collapse into one deferred frame
      if (trigger && (state_q != IDLE)) pending_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (trigger || pending_q) begin
               state_d   = LOAD;
               pending_d = 1'b0;
               led_idx_d = '0;
            end
         end
         LOAD: begin
            word_d  = blank ? '0 : scaled_word;
            lat_d   = '0;
            state_d = SEND;
         end
         SEND: begin
            px_valid = 1'b1;
            px_data  = word_q;
            px_last  = (led_idx_q == LED_LAST);
            if (px_ready) begin
               if (px_last) state_d = LATCH;
               else         led_idx_d = led_idx_q + 8'd1;
            end
         end
         LATCH: begin
            if (lat_q == LAT_LAST) begin
               frame_done  = 1'b1;
               frame_cnt_d = frame_cnt_q + 8'd1;
               state_d     = IDLE;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: flops are updated with non-blocking assignments so all of them sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pending_q   <= 1'b0;
         tick_q      <= '0;
         lat_q       <= '0;
         led_idx_q   <= '0;
         frame_cnt_q <= '0;
         word_q      <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         tick_q      <= tick_d;
         lat_q       <= lat_d;
         led_idx_q   <= led_idx_d;
         frame_cnt_q <= frame_cnt_d;
         word_q      <= word_d;
      end
   end

`ifdef NPX_BLINK_EN
   localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

   logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_off_q, blink_off_d;

   // Blink phase advances on every completed frame, whether or not blink is requested
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_off_d = blink_off_q;
      if (frame_done) begin
         if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_off_q <= blink_off_d;
      end
   end

   assign blank = blink_en & blink_off_q;
`else
   logic unused_blink;
   assign unused_blink = blink_en & (BLINK_FRAMES > 0);
   assign blank        = 1'b0;
`endif

endmodule

// File: tb/tb_npx_frame_scheduler.sv
// Directed bench for npx_frame_scheduler with a pixel scoreboard; blink expectations
// follow NPX_BLINK_EN.
module tb_npx_frame_scheduler;
   import npx_pkg::*;

   localparam int NUM_LEDS     = 4;
   localparam int LATCH_CYCLES = 8;
   localparam int FRAME_DIV    = 400;
   localparam int BLINK_FRAMES = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  base_r = 8'h00, base_g = 8'h00, base_b = 8'h00;
   logic [2:0]  shift = 3'd0;
   logic        blink_en = 1'b0;
   logic        frame_req = 1'b0;
   logic        px_ready = 1'b1;
   logic        px_valid, px_last, busy, frame_done;
   logic [23:0] px_data;
   logic [7:0]  frame_cnt;

   typedef struct packed {
      logic [23:0] data;
      logic        last;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_accepted = 0;
   int          n_done = 0;
   int          exp_cnt = 0;
   int          cyc = 0;
   int          req_cyc = 0;
   int          done_cyc = 0;
   int          last_acc_cyc = 0;
   logic        hold_chk = 1'b0;
   logic [23:0] hold_data = '0;
   logic        hold_last = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   npx_frame_scheduler #(
      .NUM_LEDS     (NUM_LEDS),
      .LATCH_CYCLES (LATCH_CYCLES),
      .FRAME_DIV    (FRAME_DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .base_r     (base_r),
      .base_g     (base_g),
      .base_b     (base_b),
      .shift      (shift),
      .blink_en   (blink_en),
      .frame_req  (frame_req),
      .px_valid   (px_valid),
      .px_data    (px_data),
      .px_last    (px_last),
      .px_ready   (px_ready),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, px_valid, 0);
      check({tag, "_data"}, px_data, 0);
      check({tag, "_last"}, px_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, frame_done, 0);
      check({tag, "_cnt"}, frame_cnt, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sb_q.delete();
      exp_cnt = 0;
      tick();
      check_idle_outputs("reset");
      tick();
      rst = 1'b0;
   endtask

   task automatic push_frame(input logic [23:0] w);
      for (int i = 0; i < NUM_LEDS; i++)
         sb_q.push_back('{data: w, last: (i == NUM_LEDS - 1)});
   endtask

   // Pulse frame_req for one cycle; returns in the LOAD cycle
   task automatic send_req(input logic [23:0] w);
      push_frame(w);
      req_cyc   = cyc;
      frame_req = 1'b1;
      tick();
      frame_req = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int target;
      int k;
      target = n_done + n;
      k = 0;
      while (n_done < target && k < 1000) begin
         tick();
         k++;
      end
      check("frame_done_seen", n_done >= target, 1);
      exp_cnt = exp_cnt + n;
      check("frame_cnt", frame_cnt, exp_cnt);
   endtask

   // Scoreboard / handshake monitor, sampling on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_chk = 1'b0;
         end else begin
            if (hold_chk) begin
               check("hold_valid", px_valid, 1);
               check("hold_data", px_data, hold_data);
               check("hold_last", px_last, hold_last);
            end
            hold_chk  = px_valid && !px_ready;
            hold_data = px_data;
            hold_last = px_last;
            if (px_valid && px_ready) begin
               n_accepted++;
               check("sb_nonempty", sb_q.size() != 0, 1);
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  check("px_data", px_data, e.data);
                  check("px_last", px_last, e.last);
               end
               if (px_last) last_acc_cyc = cyc;
            end
            if (frame_done) begin
               n_done++;
               done_cyc = cyc;
               check("latch_gap", cyc - last_acc_cyc, LATCH_CYCLES);
            end
         end
      end
   end

   initial begin
      int acc0;
      int done0;
      int k;
      logic lit;

      // Default frame, with inputs changed mid-frame to prove the snapshot holds
      do_reset();
      base_r = 8'hFF; base_g = 8'h24; base_b = 8'h90; shift = 3'd0;
      send_req(24'h90FF24);
      check("load_valid", px_valid, 0);
      check("load_busy", busy, 1);
      tick();
      check("first_valid", px_valid, 1);
      check("first_data", px_data, 24'h90FF24);
      base_r = 8'h11; shift = 3'd3;
      wait_frames(1);
      check("frame_len", done_cyc - req_cyc, NUM_LEDS + LATCH_CYCLES + 1);
      check("idle_after_frame", busy, 0);
      base_r = 8'hFF;

      // Scaling and clamp
      shift = 3'd2; send_req(24'h243F09); wait_frames(1);
      shift = 3'd7; send_req(24'h090F02); wait_frames(1);
      shift = 3'd4; send_req(24'h090F02); wait_frames(1);
      shift = 3'd0;

      // Backpressure on the second pixel
      acc0 = n_accepted;
      send_req(24'h90FF24);
      tick();
      tick();
      px_ready = 1'b0;
      repeat (5) tick();
      px_ready = 1'b1;
      wait_frames(1);
      check("bp_accepted", n_accepted - acc0, NUM_LEDS);

      // Trigger collapsing: three requests during a stalled SEND
      do_reset();
      send_req(24'h90FF24);
      px_ready = 1'b0;
      tick();
      push_frame(24'h90FF24);
      frame_req = 1'b1; tick(); frame_req = 1'b0; tick();
      frame_req = 1'b1; tick(); frame_req = 1'b0; tick();
      frame_req = 1'b1; tick(); frame_req = 1'b0;
      px_ready = 1'b1;
      wait_frames(1);
      check("pend_idle_busy", busy, 0);
      tick();
      check("pend_load_busy", busy, 1);
      check("pend_load_valid", px_valid, 0);
      tick();
      check("pend_send_valid", px_valid, 1);
      wait_frames(1);
      done0 = n_done;
      repeat (20) tick();
      check("no_extra_frame", n_done, done0);
      check("no_extra_busy", busy, 0);

      // Reset in SEND at led_idx=2, then automatic tick trigger from a fresh counter
      do_reset();
      send_req(24'h90FF24);
      tick(); tick(); tick();
      check("pre_reset_valid", px_valid, 1);
      rst = 1'b1;
      #1;
      check_idle_outputs("midreset");
      sb_q.delete();
      exp_cnt = 0;
      tick();
      tick();
      rst = 1'b0;
      push_frame(24'h90FF24);
      k = 0;
      while (!px_valid && k < 2 * FRAME_DIV) begin
         tick();
         k++;
      end
      check("auto_trigger_delay", k, FRAME_DIV + 1);
      wait_frames(1);

      // Blink phase
      do_reset();
      for (int f = 0; f < 8; f++) begin
         blink_en = (f != 6);
         lit = 1'b1;
`ifdef NPX_BLINK_EN
         lit = !(f == 2 || f == 3 || f == 7);
`endif
         send_req(lit ? 24'h90FF24 : 24'h000000);
         wait_frames(1);
      end
      blink_en = 1'b0;

      check("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
